truth_table_checker: RTL and testbench
======================================

Name: truth_table_checker

Overview:
- Synthesizable exhaustive truth-table tester for the lab's small combinational modules: 3-input and 4-input single-output functions such as the T0x and EJ02x families.
- Counterpart to the simulation stimulus benches. The bench drives vectors and prints results; this block drives every input combination into a DUT, samples the DUT's 1-bit response, and builds the captured truth table.
- Compares the captured table against an expected table and reports pass/fail, the mismatch count and the first failing index. Intended for on-board self-check of lab circuits.

Parameters:
- N_IN, 4, number of DUT inputs; legal 1..6.
- SETTLE, 2, wait cycles after driving a vector before sampling; legal 1..15.
- EXPECTED, {2**N_IN{1'b0}}, expected truth table; bit k is the required output for input vector k.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- dut_out  in  1  DUT response, treated as synchronous to clk.
- dut_in  out  N_IN  vector driven to DUT inputs; MSB corresponds to input A.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  result of last sweep: 1 when captured == EXPECTED; held until next start.
- captured  out  2**N_IN  captured truth table; bit k is dut_out sampled for vector k.
- fail_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_fail  out  N_IN  lowest vector index that mismatched; valid only when fail_valid=1.
- fail_valid  out  1  at least one mismatch recorded in the current or last sweep.

Behaviour:
- Reset: rst_n low forces state IDLE, dut_in=0, busy=0, done=0, pass=0, captured=0, fail_count=0, first_fail=0, fail_valid=0, and internal counters to 0. Reset takes effect immediately, including mid-sweep; no partial results survive.
- States:
  - IDLE: busy=0. start=1 -> DRIVE. On that edge, clear captured, fail_count, fail_valid, first_fail and pass; set index=0 and dut_in=0.
  - DRIVE: one cycle; dut_in=index; load settle counter with SETTLE-1 -> SETTLE.
  - SETTLE: decrement each cycle; at 0 -> SAMPLE.
  - SAMPLE: one cycle.
    - Capture captured[index] <= dut_out.
    - If dut_out != EXPECTED[index]: fail_count += 1; if fail_valid==0, set first_fail <= index and fail_valid <= 1.
    - If index == 2**N_IN-1 -> DONE; otherwise index += 1 -> DRIVE.
  - DONE: one cycle. done=1; pass <= (fail_count==0) using the count updated through the final SAMPLE -> IDLE.
- busy is high in DRIVE, SETTLE, SAMPLE and DONE.
- Registered outputs; dut_in changes only on the DRIVE entry edge and is held through SETTLE and SAMPLE.
- Cycles per vector: 1 (DRIVE) + SETTLE + 1 (SAMPLE). Total sweep = 2**N_IN*(SETTLE+2) + 1 cycles from the start edge to the done pulse.
  - Defaults: 16*4 + 1 = 65 cycles.
- start while busy: ignored, with no restart and no effect on results.
- start in the same cycle DONE pulses: ignored; a new sweep needs start while in IDLE.
- The index counter is N_IN+1 bits wide, so the terminal index does not wrap before the compare.
- fail_count saturates at 2**N_IN; this is the maximum possible and never overflows.
- After done, dut_in holds the last vector (2**N_IN-1) until the next start.
- Results (captured, pass, fail_count, first_fail, fail_valid) remain stable in IDLE until the next start or reset.

Test Plan:
- Pass case: N_IN=3, SETTLE=2, EXPECTED=8'b1110_1000; loopback model dut_out = majority(a,b,c); pulse start.
  - Required: done pulse exactly 33 cycles after the start edge; captured=8'hE8; pass=1; fail_count=0; fail_valid=0.
- Vector sequencing: N_IN=4, SETTLE=1.
  - Required: dut_in steps 0..15, each value held 3 cycles.
  - Required: busy high for 48 cycles plus the DONE cycle; dut_in=4'hF after done.
- Fault injection: N_IN=4, EXPECTED=16'hFFFF, DUT forced 0 for vectors 5 and 9 only.
  - Required: captured=16'hFDDF; fail_count=2; first_fail=5; fail_valid=1; pass=0.
- Constant-wrong DUT: N_IN=4, EXPECTED=16'h0000, dut_out=1.
  - Required: fail_count=16 (5'b10000); first_fail=0; pass=0.
- Mid-sweep reset and stray starts:
  - Assert rst_n=0 asynchronously during vector 6; required: all outputs 0 immediately, without waiting for a clk edge.
  - After release, start pulses issued while busy must not shorten or restart the sweep.
  - A re-run must reproduce the exact results of the pass case.

Source files
------------

// File: rtl/truth_table_checker_if.sv
// Bundle of the checker's control, DUT-facing and result signals.
// The slave modport is the checker; the master modport is whoever starts sweeps and models the DUT.
interface truth_table_checker_if #(
    parameter int N_IN = 4
) ();
    logic                   start;
    logic                   dut_out;
    logic [N_IN-1:0]        dut_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(2**N_IN)-1:0]   captured;
    logic [N_IN:0]          fail_count;
    logic [N_IN-1:0]        first_fail;
    logic                   fail_valid;

    modport master (
        output start, dut_out,
        input  dut_in, busy, done, pass, captured, fail_count, first_fail, fail_valid
    );

    modport slave (
        input  start, dut_out,
        output dut_in, busy, done, pass, captured, fail_count, first_fail, fail_valid
    );
endinterface

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table sweeper: drives every input vector into a small combinational DUT,
// samples its output after a settle delay, and scores the captured table against EXPECTED.
module truth_table_checker #(
    parameter int                   N_IN     = 4,
    parameter int                   SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0] EXPECTED = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);
    localparam int              NVEC      = 2**N_IN;
    localparam logic [N_IN:0]   LAST_IDX  = (N_IN+1)'(NVEC - 1);
    localparam logic [N_IN:0]   FC_MAX    = (N_IN+1)'(NVEC);
    localparam logic [3:0]      SCNT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [N_IN:0]          idx;
    logic [N_IN:0]          idx_inc;
    logic [3:0]             scnt;
    logic [N_IN-1:0]        dut_in_q;
    logic [NVEC-1:0]        captured_q;
    logic [N_IN:0]          fail_count_q;
    logic [N_IN-1:0]        first_fail_q;
    logic                   fail_valid_q;
    logic                   pass_q;
    logic                   last;
    logic                   mismatch;

    // idx is one bit wider than a vector so the terminal compare never sees a wrapped value
    assign idx_inc  = idx + (N_IN+1)'(1);
    assign last     = (idx == LAST_IDX);
    assign mismatch = (bus.dut_out != EXPECTED[idx[N_IN-1:0]]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_DRIVE;
            S_DRIVE:  state_nxt = S_SETTLE;
            S_SETTLE: if (scnt == 4'd0) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            scnt         <= '0;
            dut_in_q     <= '0;
            captured_q   <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        idx          <= '0;
                        dut_in_q     <= '0;
                        captured_q   <= '0;
                        fail_count_q <= '0;
                        first_fail_q <= '0;
                        fail_valid_q <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    scnt <= SCNT_LOAD;
                end
                S_SETTLE: begin
                    if (scnt != 4'd0) scnt <= scnt - 4'd1;
                end
                S_SAMPLE: begin
                    captured_q[idx[N_IN-1:0]] <= bus.dut_out;
                    if (mismatch) begin
                        if (fail_count_q != FC_MAX) fail_count_q <= fail_count_q + (N_IN+1)'(1);
                        if (!fail_valid_q) begin
                            first_fail_q <= idx[N_IN-1:0];
                            fail_valid_q <= 1'b1;
                        end
                    end
                    // dut_in only moves on the edge into DRIVE; after the last vector it is held
                    if (!last) begin
                        idx      <= idx_inc;
                        dut_in_q <= idx_inc[N_IN-1:0];
                    end
                end
                S_DONE: begin
                    pass_q <= (fail_count_q == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.pass       = pass_q;
    assign bus.captured   = captured_q;
    assign bus.fail_count = fail_count_q;
    assign bus.first_fail = first_fail_q;
    assign bus.fail_valid = fail_valid_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: three checker instances with loopback DUT models; expected sweep results
// are queued at start and popped when each sweep reports done.
module tb_truth_table_checker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(3)) b0 ();
    truth_table_checker_if #(.N_IN(4)) b1 ();
    truth_table_checker_if #(.N_IN(4)) b2 ();

    // majority(a,b,c); vectors 5 and 9 forced low; constant high
    assign b0.dut_out = (b0.dut_in[2] & b0.dut_in[1]) | (b0.dut_in[2] & b0.dut_in[0]) | (b0.dut_in[1] & b0.dut_in[0]);
    assign b1.dut_out = !(b1.dut_in == 4'd5 || b1.dut_in == 4'd9);
    assign b2.dut_out = 1'b1;

    truth_table_checker #(.N_IN(3), .SETTLE(2), .EXPECTED(8'hE8))    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    truth_table_checker #(.N_IN(4), .SETTLE(1), .EXPECTED(16'hFFFF)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    truth_table_checker #(.N_IN(4), .SETTLE(2), .EXPECTED(16'h0000)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        int          id;
        logic [15:0] cap;
        logic [4:0]  fc;
        logic [3:0]  ff;
        logic        fv;
        logic        ps;
        int          len;
        logic [3:0]  last_in;
    } exp_t;

    exp_t sb[$];
    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic peek(input int id, output logic [15:0] cap, output logic [4:0] fc, output logic [3:0] ff,
                        output logic fv, output logic ps, output logic bz, output logic dn, output logic [3:0] din);
        case (id)
            0: begin
                cap = {8'h00, b0.captured}; fc = {1'b0, b0.fail_count}; ff = {1'b0, b0.first_fail};
                fv = b0.fail_valid; ps = b0.pass; bz = b0.busy; dn = b0.done; din = {1'b0, b0.dut_in};
            end
            1: begin
                cap = b1.captured; fc = b1.fail_count; ff = b1.first_fail;
                fv = b1.fail_valid; ps = b1.pass; bz = b1.busy; dn = b1.done; din = b1.dut_in;
            end
            default: begin
                cap = b2.captured; fc = b2.fail_count; ff = b2.first_fail;
                fv = b2.fail_valid; ps = b2.pass; bz = b2.busy; dn = b2.done; din = b2.dut_in;
            end
        endcase
    endtask

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    function automatic exp_t model(input int id);
        exp_t        e;
        int          n;
        int          settle;
        logic [15:0] tbl;
        logic [3:0]  kv;
        logic        o;
        n      = (id == 0) ? 3 : 4;
        settle = (id == 1) ? 1 : 2;
        tbl    = (id == 0) ? 16'h00E8 : (id == 1) ? 16'hFFFF : 16'h0000;
        e      = '{default: 0};
        e.id   = id;
        for (int k = 0; k < (1 << n); k++) begin
            kv = 4'(k);
            case (id)
                0:       o = (kv[2] & kv[1]) | (kv[2] & kv[0]) | (kv[1] & kv[0]);
                1:       o = !(k == 5 || k == 9);
                default: o = 1'b1;
            endcase
            e.cap[k] = o;
            if (o != tbl[k]) begin
                if (!e.fv) begin
                    e.ff = 4'(k);
                    e.fv = 1'b1;
                end
                e.fc = e.fc + 5'd1;
            end
        end
        e.ps      = (e.fc == 5'd0);
        e.len     = (1 << n) * (settle + 2) + 1;
        e.last_in = 4'((1 << n) - 1);
        return e;
    endfunction

    task automatic sweep(input int id, input bit stray);
        exp_t        e;
        int          len;
        int          seq_err;
        bit          got;
        logic [15:0] cap;
        logic [4:0]  fc;
        logic [3:0]  ff, din;
        logic        fv, ps, bz, dn;
        sb.push_back(model(id));
        @(negedge clk); set_start(id, 1'b1);
        @(negedge clk); set_start(id, 1'b0);
        len = 0; seq_err = 0; got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            peek(id, cap, fc, ff, fv, ps, bz, dn, din);
            if (bz) begin
                if (id == 1 && len < 48 && din != 4'(len / 3)) seq_err++;
                len++;
            end
            if (dn) begin
                got = 1'b1;
            end else begin
                set_start(id, stray && (i == 5 || i == 20));
                @(negedge clk);
            end
        end
        chk($sformatf("done_seen%0d", id), 32'(got), 32'd1);
        // a start coinciding with the DONE cycle must not launch another sweep
        if (stray) set_start(id, 1'b1);
        @(negedge clk);
        set_start(id, 1'b0);
        peek(id, cap, fc, ff, fv, ps, bz, dn, din);
        e = sb.pop_front();
        chk($sformatf("sweep_len%0d", id), 32'(len), 32'(e.len));
        chk($sformatf("captured%0d", id), 32'(cap), 32'(e.cap));
        chk($sformatf("fail_count%0d", id), 32'(fc), 32'(e.fc));
        chk($sformatf("fail_valid%0d", id), 32'(fv), 32'(e.fv));
        if (e.fv) chk($sformatf("first_fail%0d", id), 32'(ff), 32'(e.ff));
        chk($sformatf("pass%0d", id), 32'(ps), 32'(e.ps));
        chk($sformatf("idle_busy%0d", id), 32'(bz), 32'd0);
        chk($sformatf("done_pulse%0d", id), 32'(dn), 32'd0);
        chk($sformatf("last_in%0d", id), 32'(din), 32'(e.last_in));
        if (id == 1) chk("seq_steps", 32'(seq_err), 32'd0);
        repeat (3) @(negedge clk);
        peek(id, cap, fc, ff, fv, ps, bz, dn, din);
        chk($sformatf("hold_cap%0d", id), 32'(cap), 32'(e.cap));
        chk($sformatf("hold_pass%0d", id), 32'(ps), 32'(e.ps));
    endtask

    initial begin
        logic [15:0] cap;
        logic [4:0]  fc;
        logic [3:0]  ff, din;
        logic        fv, ps, bz, dn;
        bit          found;
        rst_n = 1'b0;
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
        #1;
        peek(1, cap, fc, ff, fv, ps, bz, dn, din);
        chk("rst_all", {cap, 3'b0, fc, ff, fv, ps, bz, dn}, 32'd0);
        chk("rst_dut_in", 32'(din), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        sweep(0, 1'b0);
        sweep(1, 1'b0);
        sweep(2, 1'b0);

        // asynchronous reset while vector 6 is being applied
        @(negedge clk); b0.start = 1'b1;
        @(negedge clk); b0.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (b0.dut_in == 3'd6) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_vec6", 32'(found), 32'd1);
        peek(0, cap, fc, ff, fv, ps, bz, dn, din);
        chk("pre_rst_busy", 32'(bz), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        peek(0, cap, fc, ff, fv, ps, bz, dn, din);
        chk("midrst_flags", {cap, 3'b0, fc, ff, fv, ps, bz, dn}, 32'd0);
        chk("midrst_dut_in", 32'(din), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep(0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
